// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the regfile_sb register file slice:
//   default data/address widths, a depth helper and the busy-vector type
//   for the default configuration.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 4;

  // Number of architectural registers addressed by an addr_w-bit index.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One busy bit per register in the default configuration.
  typedef logic [depth_of(DEFAULT_ADDR_W)-1:0] busy_vec_t;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy tracking for in-flight destination writes.
//   Owns the busy bits, the issue-ready decision, the set/clear arbitration
//   and the registered count of busy registers.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   iss_valid    issue stage wants to reserve iss_dest
//   iss_dest     destination register to reserve
//   iss_ready    reservation can be accepted this cycle (combinational)
//   wb_valid     write-back strobe, clears busy[wb_addr]
//   wb_addr      write-back register
//   busy         stored busy bits, one per register
//   busy_cnt     number of busy registers (registered)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  ADDR_W   = DEFAULT_ADDR_W,
  parameter int  ZERO_REG = 1,
  localparam int DEPTH    = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [DEPTH-1:0]  busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;
  logic              wb_hits_dest;
  logic              iss_fire;
  logic              set_new;
  logic              clr_old;

  // A write-back retiring the very register being reserved frees it in
  // the same cycle, so the issue need not stall.
  assign wb_hits_dest = wb_valid && (wb_addr == iss_dest);
  assign iss_ready    = !busy_reg[iss_dest] || wb_hits_dest;
  assign iss_fire     = iss_valid && iss_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
      localparam logic [ADDR_W-1:0] IDX       = ADDR_W'(gi);
      // The hardwired zero register is never reserved.
      localparam bit                HARD_ZERO = (ZERO_REG != 0) && (gi == 0);

      assign set_vec[gi]   = iss_fire && (iss_dest == IDX) && !HARD_ZERO;
      assign clr_vec[gi]   = wb_valid && (wb_addr == IDX);
      // Set has priority: issue and write-back to the same register leave
      // it reserved for the newer producer.
      assign busy_next[gi] = set_vec[gi] || (busy_reg[gi] && !clr_vec[gi]);
    end
  endgenerate

  // At most one bit is set and one cleared per cycle, so the count moves
  // by -1, 0 or +1.
  assign set_new  = |(set_vec & ~busy_reg);
  assign clr_old  = |(clr_vec & busy_reg & ~set_vec);
  assign cnt_next = cnt_reg + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_old};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy     = busy_reg;
  assign busy_cnt = cnt_reg;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// regfile_sb
//   Parametrised register file with two combinational read ports, one
//   synchronous write-back port and a scoreboard tracking in-flight
//   destination writes (write-after-write stall on issue).
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read of the register being written this cycle returns
//                wb_data and reports not-busy
//   undefined -> reads return stored data/busy; writes visible next cycle
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   src_a, src_b      read addresses
//   a_out, b_out      read data (combinational)
//   a_busy, b_busy    pending-write flag of the addressed register
//   iss_valid         reserve iss_dest
//   iss_dest          destination register to reserve
//   iss_ready         reservation accepted this cycle if iss_valid
//   wb_valid          write-back strobe
//   wb_addr, wb_data  write-back register and data
//   busy_cnt          number of busy registers (registered)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEFAULT_DATA_W,
  parameter int  ADDR_W   = DEFAULT_ADDR_W,
  parameter int  ZERO_REG = 1,
  localparam int DEPTH    = depth_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              a_busy,
  output logic              b_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;
  logic              a_zero;
  logic              b_zero;
  logic              a_byp;
  logic              b_byp;

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt)
  );

  // Writes to the hardwired zero register are dropped.
  assign wr_en = wb_valid && !((ZERO_REG != 0) && (wb_addr == '0));

  // Storage is reset and read asynchronously, so it maps to fabric
  // registers rather than block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wb_addr] <= wb_data;
    end
  end

  assign a_zero = (ZERO_REG != 0) && (src_a == '0);
  assign b_zero = (ZERO_REG != 0) && (src_b == '0);

`ifdef REGFILE_BYPASS_EN
  assign a_byp = wb_valid && (wb_addr == src_a);
  assign b_byp = wb_valid && (wb_addr == src_b);
`else
  assign a_byp = 1'b0;
  assign b_byp = 1'b0;
`endif

  // Zero register wins over bypass, bypass wins over stored state.
  assign a_out  = a_zero ? '0 : (a_byp ? wb_data : mem_reg[src_a]);
  assign b_out  = b_zero ? '0 : (b_byp ? wb_data : mem_reg[src_b]);
  assign a_busy = !a_zero && !a_byp && busy[src_a];
  assign b_busy = !b_zero && !b_byp && busy[src_b];

endmodule : regfile_sb

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-generation register file for the datapath: two asynchronous read ports and one synchronous write-back port, plus a per-register scoreboard that tracks in-flight destination writes. The issue stage reserves a destination register and stalls on write-after-write hazards. The write-back stage retires results and clears the reservation. It replaces the fixed 16×16 register file and adds several features:
- reset
- an optional hardwired zero register
- hazard tracking
- optional write-to-read bypass

## Interface
Parameters:
- DATA_W, 16, data width of each register
- ADDR_W, 4, address width; depth is 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never marked busy

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- src_a  in  ADDR_W  read address A
- src_b  in  ADDR_W  read address B
- a_out  out  DATA_W  read data A (combinational)
- b_out  out  DATA_W  read data B (combinational)
- a_busy  out  1  register src_a has a pending write
- b_busy  out  1  register src_b has a pending write
- iss_valid  in  1  issue stage requests reservation of iss_dest
- iss_dest  in  ADDR_W  destination register to reserve
- iss_ready  out  1  reservation can be accepted this cycle (combinational)
- wb_valid  in  1  write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back data
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy (registered)

## Operation
- **Reset.** rst high at a rising edge sets:
  - every register to 0
  - every busy bit to 0
  - busy_cnt to 0

  rst overrides any issue or write-back in the same cycle. Asserting rst mid-operation discards all pending reservations.
- **Write.** When wb_valid is high, wb_data is stored at wb_addr. The write is suppressed when ZERO_REG=1 and wb_addr=0. The write always clears busy[wb_addr].
- **Write to a non-busy register.** This is legal: the data is written and the busy bit stays 0.
- **Issue handshake.** iss_ready = !busy[iss_dest] || (wb_valid && wb_addr==iss_dest). An issue is accepted when iss_valid && iss_ready, and sets busy[iss_dest].
  - iss_ready is independent of iss_valid.
  - The issue stage holds iss_dest stable while iss_valid is high and iss_ready is low.
- **Issue to register 0 with ZERO_REG=1.** Always accepted; no busy bit is set.
- **Issue and write-back to the same address in one cycle.** The issue wins: data is written and the busy bit ends set. busy_cnt is unchanged.
- **busy_cnt next value.**
  - +1 when an accepted issue sets a previously-clear bit.
  - −1 when a write-back clears a previously-set bit that is not re-set in the same cycle.
  - Both at once (different addresses): net 0.
  - The count never exceeds 2**ADDR_W (or 2**ADDR_W−1 with ZERO_REG=1).
- **Reads.**
  - a_out = reg[src_a] and b_out = reg[src_b].
  - A read of register 0 with ZERO_REG=1 returns 0 and busy 0.
  - a_busy/b_busy reflect the stored busy bits, modified as described under Configuration.

## Timing
- Write latency: 1 cycle; data is visible on the read ports the cycle after the wb_valid edge.
- Read latency: 0 cycles (combinational from the array and the busy bits).
- iss_ready: combinational from busy bits and the write-back inputs; no path from iss_valid.
- busy bit set/clear and busy_cnt update: at the same edge as the accepted issue or write-back.

## Configuration
- **REGFILE_BYPASS_EN defined.** When wb_valid is high and wb_addr equals src_a (or src_b):
  - the read port returns wb_data in the same cycle;
  - the corresponding *_busy output is forced to 0.

  Register 0 with ZERO_REG=1 still reads 0.
- **REGFILE_BYPASS_EN undefined.** Reads return the stored value and stored busy bit. The written value appears one cycle later.

## Structure
- **Package regfile_pkg.** Holds:
  - default DATA_W/ADDR_W constants;
  - a function computing the depth from ADDR_W;
  - the busy-vector typedef.
- **Sub-module regfile_scoreboard.** Owns the following, and is instantiated once inside regfile_sb:
  - busy bits;
  - iss_ready logic;
  - busy_cnt;
  - set/clear arbitration.

## Test plan
- **Reset.** Apply rst for 1 cycle after random writes → all reads 0, a_busy=b_busy=0, busy_cnt=0.
- **Write-back.** wb_valid, wb_addr=5, wb_data=16'hBEEF; next cycle src_a=5 → a_out=16'hBEEF. Same cycle (BYPASS_EN defined) → a_out=16'hBEEF.
- **Zero register.** Write 16'h1234 to register 0 with ZERO_REG=1 → a_out=0. Issue to register 0 → accepted, busy_cnt stays 0.
- **WAW stall.** Issue reg 3 → busy_cnt=1, a_busy=1 for src_a=3. Second issue to reg 3 → iss_ready=0. Write-back to reg 3 in the same cycle as the second issue → issue accepted, busy stays 1, busy_cnt=1.
- **Simultaneous issue and write-back, different regs.** Issue reg 7 plus write-back reg 3 (busy) → busy_cnt unchanged, busy[7]=1, busy[3]=0.
- **Reset mid-operation.** rst asserted with iss_valid and wb_valid high and 4 regs busy → next cycle busy_cnt=0, no write performed.
